// File: rtl/cdc_send_arb.sv
// Round-robin arbiter sharing one source-side CDC handshake sender among NREQ requesters.
// Optional watchdog (sticky err_timeout) is compiled in with CDC_ARB_WDOG_EN.
module cdc_send_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH_D  = 8,
  parameter int IDW      = 3,
  parameter int WDOG_MAX = 1023
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH_D-1:0] req_data,
  output logic [NREQ-1:0]         req_accept,
  output logic [NREQ-1:0]         req_done,
  input  logic                    snd_ready,
  output logic                    snd_send,
  output logic [WIDTH_D-1:0]      snd_data,
  output logic [IDW-1:0]          snd_id,
  output logic                    busy,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic               win_any, found_hi;
  logic [IDW-1:0]     idx_hi, idx_lo, win_idx;
  logic [WIDTH_D-1:0] win_data;
  logic               grant, done_ev;

  // Lowest valid index at/after ptr wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    win_any  = 1'b0;
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_any = 1'b1;
        idx_lo  = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = IDW'(i);
        end
      end
    end
    win_idx  = found_hi ? idx_hi : idx_lo;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_data = req_data[i*WIDTH_D +: WIDTH_D];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    done_ev    = 1'b0;
    req_accept = '0;
    req_done   = '0;
    case (state_q)
      IDLE: begin
        if (snd_ready && win_any) begin
          grant   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:  if (snd_ready) state_d = WAIT_LO;
      WAIT_LO: if (!snd_ready) state_d = WAIT_HI;
      WAIT_HI: begin
        if (snd_ready) begin
          done_ev = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req_accept[i] = grant && (win_idx == IDW'(i));
      req_done[i]   = done_ev && (snd_id == IDW'(i));
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      snd_data <= '0;
      snd_id   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        snd_data <= win_data;
        snd_id   <= win_idx;
      end
      if (done_ev) begin
        ptr_q <= (snd_id == IDW'(NREQ - 1)) ? '0 : snd_id + IDW'(1);
      end
    end
  end

  assign snd_send = (state_q == LAUNCH);
  assign busy     = (state_q != IDLE);

`ifdef CDC_ARB_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        err_q;

  // Counts the time spent waiting for the far-domain acknowledge; the FSM never aborts.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == LAUNCH && state_d == WAIT_LO) begin
        wdog_cnt <= '0;
      end else if ((state_q == WAIT_LO || state_q == WAIT_HI) && wdog_cnt != 16'hFFFF) begin
        wdog_cnt <= wdog_cnt + 16'd1;
      end
      if (wdog_cnt == 16'(WDOG_MAX)) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/cdc_send_arb.md
# cdc_send_arb

Round-robin scheduler that shares one source-side CDC handshake sender between NREQ requesters in the aclk domain. Each requester offers a WIDTH_D word. The block grants one requester at a time and presents its word to the sender with a single-cycle send strobe. It then tracks the sender's ready/busy cycle and pulses a per-requester done when the far domain has acknowledged the word.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH_D, 8, data word width; must match the shared sender
- IDW, 3, width of the granted-requester index; NREQ <= 2**IDW
- WDOG_MAX, 1023, watchdog limit in cycles (used only with CDC_ARB_WDOG_EN)

Ports:
- aclk  in  1  source-domain clock
- arst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester offer; held until its req_accept
- req_data  in  NREQ*WIDTH_D  requester i word in bits [i*WIDTH_D +: WIDTH_D]
- req_accept  out  NREQ  one-hot, 1-cycle; the word is captured this cycle
- req_done  out  NREQ  one-hot, 1-cycle; the word has been acknowledged by the far domain
- snd_ready  in  1  sender ready (high = idle, low = transfer outstanding)
- snd_send  out  1  send strobe to the sender
- snd_data  out  WIDTH_D  word to the sender; stable from grant until the next grant
- snd_id  out  IDW  index of the current or last granted requester
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, LAUNCH, WAIT_LO, WAIT_HI.
- IDLE, with snd_ready=1 and any req_valid:
  - Winner = first set req_valid at or after ptr, wrapping modulo NREQ.
  - req_accept[winner]=1 combinationally this cycle.
  - snd_data<=req_data[winner]; snd_id<=winner; next state LAUNCH.
- IDLE with snd_ready=0: no grant, stay in IDLE.
- LAUNCH: snd_send=1.
  - snd_ready=1 this cycle: next state WAIT_LO.
  - snd_ready=0: stay in LAUNCH with snd_send held high.
- WAIT_LO: stay until snd_ready=0, then go to WAIT_HI.
- WAIT_HI: stay until snd_ready=1. On that cycle:
  - req_done[snd_id]=1.
  - ptr<=(snd_id+1) mod NREQ.
  - next state IDLE.
- Only one transfer is in flight at a time. req_done always matches the earlier req_accept of the same index.
- A requester that drops req_valid before accept is never granted. The data is not sampled.
- Reset values:
  - state=IDLE, ptr=0, snd_data=0, snd_id=0.
  - snd_send=0, req_accept=0, req_done=0, busy=0, err_timeout=0.
- Reset mid-transfer returns to IDLE immediately, with no req_done. The sender shares arst_n and aborts as well.

## Timing
- Cycle 0: IDLE, snd_ready=1, req_valid asserted → req_accept pulses in cycle 0.
- Cycle 1: snd_send=1 with snd_data valid.
- Cycle 2: sender drops snd_ready → WAIT_LO moves to WAIT_HI.
- Cycle k: snd_ready returns high → req_done in cycle k. A new grant is possible in cycle k+1.
- snd_send is never high outside LAUNCH, and is never high for more than one cycle while snd_ready=1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
- The accept and done paths are combinational from snd_ready and req_valid. All other outputs are registered.

## Configuration
- Macro CDC_ARB_WDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_LO and increments each cycle in WAIT_LO/WAIT_HI, saturating.
  - When the counter reaches WDOG_MAX, err_timeout sets. It stays set until arst_n.
  - The FSM keeps waiting; no abort.
- Undefined: no counter; err_timeout is tied to 0.

## Test plan
- Single request: req_valid=4'b0010, data 0xA5, sender model acks after 6 cycles → req_accept[1] in cycle 0; snd_send in cycle 1 with snd_data=0xA5, snd_id=1; one req_done[1] when snd_ready rises.
- Contention: req_valid=4'b1111 held, ptr=0 → accept order 0,1,2,3,0. Exactly one transfer is in flight at any time.
- Skip after wrap: ptr=3, req_valid=4'b0101 → grant 0, then 2.
- Stall in LAUNCH: force snd_ready=0 for 3 cycles during LAUNCH → snd_send stays high for 4 cycles. Exactly one send is captured; done still pulses once.
- Watchdog (macro on, WDOG_MAX=20): sender never acks → err_timeout=1 after 20 cycles in WAIT; the flag remains set after a late ack. With the macro off, err_timeout stays 0.
- Reset in WAIT_HI: assert arst_n low → all outputs go to their reset values asynchronously; no req_done. After release, the next grant starts from requester 0.
